// File: rtl/udp_reg_cmd_master.sv
// Host-side initiator for the UDP register-access protocol: serialises a register request
// into a ':'-framed command on tx and, for reads, collects and checks the rx response.
module udp_reg_cmd_master #(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned UPPER_CMD      = 0,
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [REG_WIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_status,
  output logic [REG_WIDTH-1:0] rsp_rdata,
  output logic [7:0]           o_tx_udp_payload_axis_tdata,
  output logic                 o_tx_udp_payload_axis_tvalid,
  input  logic                 i_tx_udp_payload_axis_tready,
  output logic                 o_tx_udp_payload_axis_tlast,
  output logic                 o_tx_udp_payload_axis_tuser,
  input  logic [7:0]           i_rx_udp_payload_axis_tdata,
  input  logic                 i_rx_udp_payload_axis_tvalid,
  output logic                 o_rx_udp_payload_axis_tready,
  input  logic                 i_rx_udp_payload_axis_tlast,
  input  logic                 i_rx_udp_payload_axis_tuser
);

  localparam int unsigned NB = REG_WIDTH / 8;
  localparam int unsigned CW = $clog2(NB + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CH_W = (UPPER_CMD != 0) ? 8'h57 : 8'h77;
  localparam logic [7:0] CH_R = (UPPER_CMD != 0) ? 8'h52 : 8'h72;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_FRAME   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_COLON, S_TX_ADDR, S_TX_CMD, S_TX_DATA, S_RX_WAIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic [REG_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]           tx_tdata_q, tx_tdata_d;
  logic                 tx_tvalid_q, tx_tvalid_d;
  logic                 tx_tlast_q, tx_tlast_d;
  logic                 rx_tready_q, rx_tready_d;

  logic tx_hs_c;
  logic rx_hs_c;

  assign tx_hs_c = tx_tvalid_q & i_tx_udp_payload_axis_tready;
  assign rx_hs_c = i_rx_udp_payload_axis_tvalid & rx_tready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rx_shift_q   <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_rdata_q  <= '0;
      tx_tdata_q   <= 8'h00;
      tx_tvalid_q  <= 1'b0;
      tx_tlast_q   <= 1'b0;
      rx_tready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rx_shift_q   <= rx_shift_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      tx_tdata_q   <= tx_tdata_d;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_tlast_q   <= tx_tlast_d;
      rx_tready_q  <= rx_tready_d;
    end
  end

  // Next-state and registered-output logic; each tx state names the byte currently on the bus.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rx_shift_d   = rx_shift_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    tx_tdata_d   = tx_tdata_q;
    tx_tvalid_d  = tx_tvalid_q;
    tx_tlast_d   = tx_tlast_q;
    rx_tready_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          data_d      = cmd_wdata;
          cmd_ready_d = 1'b0;
          tx_tdata_d  = 8'h3A;
          tx_tvalid_d = 1'b1;
          tx_tlast_d  = 1'b0;
          state_d     = S_TX_COLON;
        end
      end
      S_TX_COLON: begin
        if (tx_hs_c) begin
          tx_tdata_d = 8'h30 + 8'(addr_q);
          state_d    = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        if (tx_hs_c) begin
          tx_tdata_d = write_q ? CH_W : CH_R;
          tx_tlast_d = ~write_q;
          state_d    = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        if (tx_hs_c) begin
          if (write_q) begin
            tx_tdata_d = data_q[REG_WIDTH-1 -: 8];
            data_d     = data_q << 8;
            tx_tlast_d = (NB == 1);
            byte_cnt_d = CW'(1);
            state_d    = S_TX_DATA;
          end else begin
            tx_tvalid_d = 1'b0;
            tx_tlast_d  = 1'b0;
            byte_cnt_d  = '0;
            rx_shift_d  = '0;
            timer_d     = '0;
            state_d     = S_RX_WAIT;
          end
        end
      end
      S_TX_DATA: begin
        if (tx_hs_c) begin
          if (byte_cnt_q == CW'(NB)) begin
            tx_tvalid_d  = 1'b0;
            tx_tlast_d   = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            state_d      = S_DONE;
          end else begin
            tx_tdata_d = data_q[REG_WIDTH-1 -: 8];
            data_d     = data_q << 8;
            tx_tlast_d = (byte_cnt_q == CW'(NB - 1));
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      S_RX_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (rx_hs_c) begin
          rx_shift_d = (rx_shift_q << 8) | REG_WIDTH'(i_rx_udp_payload_axis_tdata);
          // Saturate at NB+1 so overlong frames stay distinguishable from exact ones.
          if (byte_cnt_q != CW'(NB + 1)) begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
        if (rx_hs_c && i_rx_udp_payload_axis_tlast) begin
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
          if ((byte_cnt_q == CW'(NB - 1)) && !i_rx_udp_payload_axis_tuser) begin
            rsp_status_d = ST_OK;
            rsp_rdata_d  = rx_shift_d;
          end else begin
            rsp_status_d = ST_FRAME;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        tx_tvalid_d = 1'b0;
        tx_tlast_d  = 1'b0;
      end
    endcase
  end

  assign cmd_ready                    = cmd_ready_q;
  assign rsp_valid                    = rsp_valid_q;
  assign rsp_status                   = rsp_status_q;
  assign rsp_rdata                    = rsp_rdata_q;
  assign o_tx_udp_payload_axis_tdata  = tx_tdata_q;
  assign o_tx_udp_payload_axis_tvalid = tx_tvalid_q;
  assign o_tx_udp_payload_axis_tlast  = tx_tlast_q;
  assign o_tx_udp_payload_axis_tuser  = 1'b0;
  assign o_rx_udp_payload_axis_tready = rx_tready_q;

endmodule

// File: tb/tb_udp_reg_cmd_master.sv
// Scoreboard bench for udp_reg_cmd_master: drivers queue expected tx bytes and responses,
// a negedge monitor pops and compares them, including response timing.
module tb_udp_reg_cmd_master;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned UPPER = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_addr = 2'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic        tx_tlast;
  logic        tx_tuser;
  logic [7:0]  rx_tdata = 8'd0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic        rx_tlast = 1'b0;
  logic        rx_tuser = 1'b0;

  udp_reg_cmd_master #(
    .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .TIMEOUT_CYCLES(TIMEOUT), .UPPER_CMD(UPPER)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .o_tx_udp_payload_axis_tdata(tx_tdata), .o_tx_udp_payload_axis_tvalid(tx_tvalid),
    .i_tx_udp_payload_axis_tready(tx_tready), .o_tx_udp_payload_axis_tlast(tx_tlast),
    .o_tx_udp_payload_axis_tuser(tx_tuser),
    .i_rx_udp_payload_axis_tdata(rx_tdata), .i_rx_udp_payload_axis_tvalid(rx_tvalid),
    .o_rx_udp_payload_axis_tready(rx_tready), .i_rx_udp_payload_axis_tlast(rx_tlast),
    .i_rx_udp_payload_axis_tuser(rx_tuser)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic [1:0]  kind;   // 0: after tx tlast, 1: after rx tlast, 2: timeout after tx tlast
  } rsp_exp_t;

  logic [8:0] txq[$];
  rsp_exp_t   rspq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tx_cyc = 0;
  int last_rx_cyc = 0;
  int tx_hs_cnt = 0;
  int tready_mode = 0;
  logic       stall_q = 1'b0;
  logic [8:0] stall_val = 9'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Sink back-pressure: steady ready or a 1/0 toggle.
  always @(posedge clk) begin
    #1;
    if (tready_mode != 0) tx_tready = ~tx_tready;
    else tx_tready = 1'b1;
  end

  // Monitor: tx bytes, hold-while-stalled, rx tlast timing, and responses.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("tx_hold_valid", 64'(tx_tvalid), 64'd1);
        check("tx_hold_data", 64'({tx_tlast, tx_tdata}), 64'(stall_val));
      end
      stall_q   = tx_tvalid & ~tx_tready;
      stall_val = {tx_tlast, tx_tdata};
      if (tx_tvalid && tx_tready) begin
        tx_hs_cnt++;
        if (txq.size() == 0) begin
          fail_now($sformatf("tx_unexpected byte %0h", tx_tdata));
        end else begin
          check("tx_byte", 64'({tx_tlast, tx_tdata}), 64'(txq.pop_front()));
          check("tx_tuser", 64'(tx_tuser), 64'd0);
        end
        if (tx_tlast) last_tx_cyc = cyc;
      end
      if (rx_tvalid && rx_tready && rx_tlast) last_rx_cyc = cyc;
      if (rsp_valid) begin
        if (rspq.size() == 0) begin
          fail_now($sformatf("rsp_unexpected status %0h", rsp_status));
        end else begin
          rsp_exp_t r;
          int due;
          r = rspq.pop_front();
          check("rsp_status", 64'(rsp_status), 64'(r.status));
          if (r.chk_rdata) check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          case (r.kind)
            2'd0:    due = last_tx_cyc + 1;
            2'd1:    due = last_rx_cyc + 1;
            default: due = last_tx_cyc + 1 + int'(TIMEOUT);
          endcase
          check("rsp_cycle", 64'(cyc), 64'(due));
        end
      end
    end
  end

  task automatic push_frame(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                            input int nmax);
    logic [7:0] b[7];
    int total;
    total = wr ? 7 : 3;
    b[0] = 8'h3A;
    b[1] = 8'h30 + {6'd0, addr};
    b[2] = wr ? 8'h57 : 8'h52;
    b[3] = wd[31:24];
    b[4] = wd[23:16];
    b[5] = wd[15:8];
    b[6] = wd[7:0];
    for (int i = 0; i < total && i < nmax; i++) txq.push_back({(i == total - 1), b[i]});
  endtask

  task automatic push_rsp(input logic [1:0] st, input logic [31:0] rd, input logic chk,
                          input logic [1:0] kind);
    rsp_exp_t r;
    r.status = st;
    r.rdata = rd;
    r.chk_rdata = chk;
    r.kind = kind;
    rspq.push_back(r);
  endtask

  task automatic issue(input logic wr, input logic [1:0] addr, input logic [31:0] wd);
    int k;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) fail_now("cmd_ready_wait_expired");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx_empty();
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (txq.size() != 0 && k < 200);
    if (txq.size() != 0) fail_now("tx_frame_wait_expired");
  endtask

  task automatic wait_rsp_empty();
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (rspq.size() != 0 && k < 200);
    if (rspq.size() != 0) fail_now("rsp_wait_expired");
    repeat (2) @(posedge clk);
  endtask

  // Sends n bytes (n <= 8), taken MSB first from bytes_be; tuser_last marks the tlast beat bad.
  task automatic send_rx(input int n, input logic [63:0] bytes_be, input logic tuser_last);
    int k;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_tvalid = 1'b1;
      rx_tdata  = bytes_be[8*(n-1-i) +: 8];
      rx_tlast  = (i == n - 1);
      rx_tuser  = (i == n - 1) && tuser_last;
      k = 0;
      @(negedge clk);
      while (!rx_tready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!rx_tready) fail_now("rx_tready_wait_expired");
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  initial begin
    #200000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tx_tlast", 64'(tx_tlast), 64'd0);
    check("rst_tx_tdata", 64'(tx_tdata), 64'd0);
    check("rst_rx_tready", 64'(rx_tready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Posted write, sink always ready.
    push_frame(1'b1, 2'd2, 32'hABCD1234, 7);
    push_rsp(2'b00, 32'h0, 1'b0, 2'd0);
    issue(1'b1, 2'd2, 32'hABCD1234);
    wait_rsp_empty();

    // Good read.
    push_frame(1'b0, 2'd2, 32'h0, 3);
    push_rsp(2'b00, 32'hABCD1234, 1'b1, 2'd1);
    issue(1'b0, 2'd2, 32'h0);
    wait_tx_empty();
    send_rx(4, 64'hABCD1234, 1'b0);
    wait_rsp_empty();

    // Write under toggling back-pressure.
    tready_mode = 1;
    push_frame(1'b1, 2'd1, 32'h5A0FF0A5, 7);
    push_rsp(2'b00, 32'h0, 1'b0, 2'd0);
    issue(1'b1, 2'd1, 32'h5A0FF0A5);
    wait_rsp_empty();
    tready_mode = 0;
    repeat (2) @(posedge clk);

    // Short frame, overlong frame, tuser on tlast.
    push_frame(1'b0, 2'd3, 32'h0, 3);
    push_rsp(2'b01, 32'h0, 1'b0, 2'd1);
    issue(1'b0, 2'd3, 32'h0);
    wait_tx_empty();
    send_rx(2, 64'hFEDC, 1'b0);
    wait_rsp_empty();

    push_frame(1'b0, 2'd0, 32'h0, 3);
    push_rsp(2'b01, 32'h0, 1'b0, 2'd1);
    issue(1'b0, 2'd0, 32'h0);
    wait_tx_empty();
    send_rx(6, 64'h112233445566, 1'b0);
    wait_rsp_empty();

    push_frame(1'b0, 2'd1, 32'h0, 3);
    push_rsp(2'b01, 32'h0, 1'b0, 2'd1);
    issue(1'b0, 2'd1, 32'h0);
    wait_tx_empty();
    send_rx(4, 64'h99887766, 1'b1);
    wait_rsp_empty();

    // Good read after errors refreshes rdata.
    push_frame(1'b0, 2'd3, 32'h0, 3);
    push_rsp(2'b00, 32'h00FF7E81, 1'b1, 2'd1);
    issue(1'b0, 2'd3, 32'h0);
    wait_tx_empty();
    send_rx(4, 64'h00FF7E81, 1'b0);
    wait_rsp_empty();

    // Timeout: rdata unchanged, late frame discarded in IDLE.
    push_frame(1'b0, 2'd1, 32'h0, 3);
    push_rsp(2'b10, 32'h00FF7E81, 1'b1, 2'd2);
    issue(1'b0, 2'd1, 32'h0);
    wait_rsp_empty();
    send_rx(4, 64'h11223344, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("late_frame_rdata", 64'(rsp_rdata), 64'h00FF7E81);
    check("late_frame_status", 64'(rsp_status), 64'd2);

    // Reset after three write bytes: frame abandoned, no response.
    push_frame(1'b1, 2'd2, 32'hDEADBEEF, 3);
    base = tx_hs_cnt;
    issue(1'b1, 2'd2, 32'hDEADBEEF);
    begin
      int k;
      k = 0;
      while (tx_hs_cnt < base + 3 && k < 100) begin
        @(negedge clk); #1;
        k++;
      end
      if (tx_hs_cnt < base + 3) fail_now("reset_test_wait_expired");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    push_frame(1'b0, 2'd3, 32'h0, 3);
    push_rsp(2'b00, 32'h0BADF00D, 1'b1, 2'd1);
    issue(1'b0, 2'd3, 32'h0);
    wait_tx_empty();
    send_rx(4, 64'h0BADF00D, 1'b0);
    wait_rsp_empty();

    repeat (5) @(posedge clk);
    check("txq_drained", 64'(txq.size()), 64'd0);
    check("rspq_drained", 64'(rspq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
